// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order,
// active-low hex patterns and the all-dark codes.
package seg_pkg;

  // Segment bit order on seg_n, MSB first.
  typedef struct packed {
    logic dp;
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] DIG_OFF   = 6'h3F;

  // Active-low {dp,g..a} with dp off, indexed by nibble value.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low {g..a} segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  logic [7:0] pattern;

  always_comb begin
    pattern = SEG_HEX[nibble];
    seg_n   = pattern[6:0];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 6-digit common-anode display scanner with ghost guard,
// per-digit blanking and decimal points. All outputs are registered.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_DIGITS   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] data_in,
  input  logic [5:0] dp_in,
  input  logic [5:0] blank_mask,
  output logic [2:0] sel,
  output logic [5:0] dig_n,
  output logic [7:0] seg_n,
  output logic       frame_tick
);

  localparam int              CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   GUARD_END = CW'(BLANK_CYCLES);
  localparam logic [2:0]      SEL_LAST  = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] div_cnt;
  logic [6:0]    hex_n;
  logic          slot_end;
  logic          guard;
  logic          masked;
  logic [5:0]    dig_nxt;
  seg_t          seg_nxt;
  seg_t          seg_q;

  hex_to_seg u_hex (
    .nibble (data_in),
    .seg_n  (hex_n)
  );

  // Guard looks at the pre-edge count, so the first BLANK_CYCLES output
  // cycles of a slot are dark while the mux settles onto the new sel.
  always_comb begin
    slot_end = (div_cnt == DIV_LAST);
    guard    = (div_cnt < GUARD_END);
    masked   = blank_mask[sel];
    dig_nxt  = DIG_OFF;
    if (!guard && !masked) dig_nxt = ~(6'b1 << sel);
    seg_nxt  = seg_t'(SEG_BLANK);
    if (!masked) seg_nxt = seg_t'({~dp_in[sel], hex_n});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      sel        <= '0;
      dig_n      <= DIG_OFF;
      seg_q      <= seg_t'(SEG_BLANK);
      frame_tick <= 1'b0;
    end else if (en) begin
      div_cnt    <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) sel <= (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
      dig_n      <= dig_nxt;
      seg_q      <= seg_nxt;
      frame_tick <= slot_end && (sel == SEL_LAST);
    end else begin
      dig_n      <= DIG_OFF;
      seg_q      <= seg_t'(SEG_BLANK);
      frame_tick <= 1'b0;
    end
  end

  assign seg_n = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random
// traffic, checked against a position-based model of the scan.
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int NDIG     = 6;
  localparam int FRAME    = SCAN_DIV * NDIG;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] data_in;
  logic [5:0] dp_in;
  logic [5:0] blank_mask;
  logic [2:0] sel;
  logic [5:0] dig_n;
  logic [7:0] seg_n;
  logic       frame_tick;

  logic [3:0] digits [6];
  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Scoreboard entries: {frame_tick, sel, dig_n, seg_n}
  logic [17:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int pos    = 0;   // model position within the frame, 0..FRAME-1
  int cycle  = 0;
  int ticks  = 0;

  seg_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK),
    .NUM_DIGITS   (NDIG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .sel        (sel),
    .dig_n      (dig_n),
    .seg_n      (seg_n),
    .frame_tick (frame_tick)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Upstream 6:1 nibble mux driven by the DUT's select
  always_comb data_in = (sel < 3'd6) ? digits[sel] : 4'h0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", tag, cycle, got, exp);
    end
  endtask

  // One clock: drive inputs, predict the post-edge outputs, then compare.
  task automatic step(input logic r, input logic e);
    int          s, d;
    logic [5:0]  ed;
    logic [7:0]  es;
    logic        et;
    logic [17:0] got_e;
    @(negedge clk);
    rst = r;
    en  = e;
    #1;
    s = pos / SCAN_DIV;
    d = pos % SCAN_DIV;
    ed = 6'h3F;
    es = 8'hFF;
    et = 1'b0;
    if (r) begin
      pos = 0;
    end else if (e) begin
      if (!blank_mask[s]) begin
        es = {~dp_in[s], seg_tab[digits[s]][6:0]};
        if (d >= BLANK) ed = ~(6'b1 << s);
      end
      et  = (pos == FRAME - 1);
      pos = (pos + 1) % FRAME;
    end
    exp_q.push_back({et, 3'(pos / SCAN_DIV), ed, es});
    @(posedge clk);
    #1;
    cycle++;
    got_e = exp_q.pop_front();
    check("sel",        {5'd0, sel},        {5'd0, got_e[16:14]});
    check("dig_n",      {2'd0, dig_n},      {2'd0, got_e[13:8]});
    check("seg_n",      seg_n,              got_e[7:0]);
    check("frame_tick", {7'd0, frame_tick}, {7'd0, got_e[17]});
    if (frame_tick) ticks++;
  endtask

  task automatic set_default_digits();
    for (int i = 0; i < NDIG; i++) digits[i] = 4'(i + 1);
  endtask

  initial begin
    int v;
    int t0;
    rst = 1'b1; en = 1'b0; dp_in = '0; blank_mask = '0;
    set_default_digits();

    // Reset state
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Basic scan: two frames plus one slot, exactly one tick per frame
    t0 = ticks;
    for (int i = 0; i < 2 * FRAME + SCAN_DIV; i++) step(1'b0, 1'b1);
    check("ticks_per_2frames", 8'(ticks - t0), 8'd2);

    // Nibble sweep on digit 0: advance the value every lit slot-0 cycle
    v = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      digits[0] = 4'(v);
      if (pos / SCAN_DIV == 0 && pos % SCAN_DIV >= BLANK) v++;
      step(1'b0, 1'b1);
    end
    set_default_digits();

    // Decimal point on digit 2
    dp_in = 6'b000100;
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1);
    dp_in = '0;

    // Blank digit 5
    blank_mask = 6'b100000;
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1);
    blank_mask = '0;

    // Drop enable at sel=3, div_cnt=5 for 10 cycles, then resume
    for (int i = 0; i < FRAME && pos != 3 * SCAN_DIV + 5; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 2 * SCAN_DIV; i++) step(1'b0, 1'b1);

    // Reset at sel=4, div_cnt=6 with en still high
    for (int i = 0; i < FRAME && pos != 4 * SCAN_DIV + 6; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 2 * SCAN_DIV + 4; i++) step(1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NDIG; k++) digits[k] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) dp_in = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 31) == 0) blank_mask = 6'($urandom_range(0, 63));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
